// File: rtl/sample_conditioner_pkg.sv
// Shared constants for the sample conditioner: FSM state encoding and the
// filter input widths this block feeds.
package sample_conditioner_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CAL   = 2'd1;
    localparam logic [1:0] ST_LATCH = 2'd2;

    localparam int SC_WX = 12;
    localparam int SC_WD = 14;

    function automatic logic state_is_busy(input logic [1:0] st);
        logic busy;
        case (st)
            ST_CAL:   busy = 1'b1;
            ST_LATCH: busy = 1'b1;
            default:  busy = 1'b0;
        endcase
        return busy;
    endfunction

endpackage

// File: rtl/offset_cal_chan.sv
// One conditioning channel: offset-binary to two's complement, calibration
// accumulator, offset register and saturating offset removal.
module offset_cal_chan
    import sample_conditioner_pkg::*;
#(
    parameter int W        = 12,
    parameter int CAL_LOG2 = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [W-1:0]        adc,
    input  logic                load_out,
    input  logic                zero_out,
    input  logic                acc_clr,
    input  logic                acc_en,
    input  logic                ofs_load,
    output logic signed [W-1:0] y_out,
    output logic signed [W-1:0] ofs
);

    localparam int WA = W + CAL_LOG2;

    logic signed [W-1:0]  conv_s;
    logic signed [W:0]    diff_s;
    logic signed [WA-1:0] acc_r;
    logic signed [W-1:0]  ofs_r;
    logic signed [W-1:0]  y_r;

    function automatic logic signed [W-1:0] sat_w(input logic signed [W:0] v);
        logic signed [W-1:0] r;
        if (v[W] != v[W-1]) begin
            r = v[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            r = v[W-1:0];
        end
        return r;
    endfunction

    assign conv_s = {~adc[W-1], adc[W-2:0]};
    assign diff_s = {conv_s[W-1], conv_s} - {ofs_r[W-1], ofs_r};

    // Output sample, accumulator and offset registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y_r   <= {W{1'b0}};
            acc_r <= {WA{1'b0}};
            ofs_r <= {W{1'b0}};
        end else begin
            if (zero_out) begin
                y_r <= {W{1'b0}};
            end else if (load_out) begin
                y_r <= sat_w(diff_s);
            end else begin
                y_r <= y_r;
            end
            if (acc_clr) begin
                acc_r <= {WA{1'b0}};
            end else if (acc_en) begin
                acc_r <= acc_r + {{CAL_LOG2{conv_s[W-1]}}, conv_s};
            end else begin
                acc_r <= acc_r;
            end
            // Mean by dropping the low bits: floor division of the signed sum.
            if (ofs_load) begin
                ofs_r <= acc_r[WA-1:CAL_LOG2];
            end else begin
                ofs_r <= ofs_r;
            end
        end
    end

    assign y_out = y_r;
    assign ofs   = ofs_r;

endmodule

// File: rtl/sample_conditioner.sv
// Two-channel ADC sample conditioner with on-demand DC-offset calibration.
// The FSM and sample counter live here; per-channel datapaths are sub-modules.
module sample_conditioner
    import sample_conditioner_pkg::*;
#(
    parameter int CAL_LOG2 = 8,
    parameter int WX       = SC_WX,
    parameter int WD       = SC_WD
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WX-1:0]        adc_x,
    input  logic [WD-1:0]        adc_d,
    input  logic                 adc_valid,
    input  logic                 cal_start,
    output logic signed [WX-1:0] x_out,
    output logic signed [WD-1:0] d_out,
    output logic                 out_valid,
    output logic                 cal_busy,
    output logic                 cal_done,
    output logic signed [WX-1:0] ofs_x,
    output logic signed [WD-1:0] ofs_d
);

    logic [1:0]          state_r;
    logic [1:0]          state_next_s;
    logic [CAL_LOG2-1:0] cnt_r;
    logic                out_valid_r;
    logic                cal_busy_r;
    logic                cal_done_r;
    logic                load_out_s;
    logic                zero_out_s;
    logic                acc_clr_s;
    logic                acc_en_s;
    logic                ofs_load_s;

    // Datapath controls derived from the current state.
    always_comb begin
        load_out_s = adc_valid && (state_r != ST_CAL);
        zero_out_s = (state_r == ST_CAL);
        acc_clr_s  = (state_r == ST_IDLE) && cal_start;
        acc_en_s   = (state_r == ST_CAL) && adc_valid;
        ofs_load_s = (state_r == ST_LATCH);
    end

    // Next-state logic; cal_start only matters in IDLE.
    always_comb begin
        state_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (cal_start) begin
                    state_next_s = ST_CAL;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CAL: begin
                if (adc_valid && (cnt_r == {CAL_LOG2{1'b1}})) begin
                    state_next_s = ST_LATCH;
                end else begin
                    state_next_s = ST_CAL;
                end
            end
            ST_LATCH: state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // State, sample counter and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CAL_LOG2{1'b0}};
            out_valid_r <= 1'b0;
            cal_busy_r  <= 1'b0;
            cal_done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (acc_clr_s) begin
                cnt_r <= {CAL_LOG2{1'b0}};
            end else if (acc_en_s) begin
                cnt_r <= cnt_r + 1'b1;
            end else begin
                cnt_r <= cnt_r;
            end
            out_valid_r <= load_out_s;
            cal_busy_r  <= state_is_busy(state_next_s);
            cal_done_r  <= (state_next_s == ST_LATCH);
        end
    end

    offset_cal_chan #(.W(WX), .CAL_LOG2(CAL_LOG2)) u_chan_x (
        .clk      (clk),
        .reset    (reset),
        .adc      (adc_x),
        .load_out (load_out_s),
        .zero_out (zero_out_s),
        .acc_clr  (acc_clr_s),
        .acc_en   (acc_en_s),
        .ofs_load (ofs_load_s),
        .y_out    (x_out),
        .ofs      (ofs_x)
    );

    offset_cal_chan #(.W(WD), .CAL_LOG2(CAL_LOG2)) u_chan_d (
        .clk      (clk),
        .reset    (reset),
        .adc      (adc_d),
        .load_out (load_out_s),
        .zero_out (zero_out_s),
        .acc_clr  (acc_clr_s),
        .acc_en   (acc_en_s),
        .ofs_load (ofs_load_s),
        .y_out    (d_out),
        .ofs      (ofs_d)
    );

    assign out_valid = out_valid_r;
    assign cal_busy  = cal_busy_r;
    assign cal_done  = cal_done_r;

endmodule

// File: tb/tb_sample_conditioner.sv
// Self-checking bench for sample_conditioner: vector table, directed
// calibration sequences and random traffic against a behavioural model.
module tb_sample_conditioner;

    localparam int WX = 12;
    localparam int WD = 14;
    localparam int CL = 8;
    localparam int N  = 1 << CL;

    logic                 clk;
    logic                 reset;
    logic [WX-1:0]        adc_x;
    logic [WD-1:0]        adc_d;
    logic                 adc_valid;
    logic                 cal_start;
    logic signed [WX-1:0] x_out;
    logic signed [WD-1:0] d_out;
    logic                 out_valid;
    logic                 cal_busy;
    logic                 cal_done;
    logic signed [WX-1:0] ofs_x;
    logic signed [WD-1:0] ofs_d;

    sample_conditioner #(.CAL_LOG2(CL), .WX(WX), .WD(WD)) dut (
        .clk(clk), .reset(reset), .adc_x(adc_x), .adc_d(adc_d),
        .adc_valid(adc_valid), .cal_start(cal_start), .x_out(x_out),
        .d_out(d_out), .out_valid(out_valid), .cal_busy(cal_busy),
        .cal_done(cal_done), .ofs_x(ofs_x), .ofs_d(ofs_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int done_count = 0;

    // Behavioural model: mode 0 = passing samples, 1 = gathering, 2 = latching
    int m_mode, m_sum_x, m_sum_d, m_n, m_ofs_x, m_ofs_d, m_x, m_d;
    int m_ov, m_busy, m_done;

    typedef struct {
        bit v;
        int x;
        int d;
        int ex;
        int ed;
        int eov;
    } vec_t;
    vec_t tbl[6];

    function automatic int sat(input int v, input int w);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        m_mode = 0; m_sum_x = 0; m_sum_d = 0; m_n = 0;
        m_ofs_x = 0; m_ofs_d = 0; m_x = 0; m_d = 0;
        m_ov = 0; m_busy = 0; m_done = 0;
    endtask

    task automatic model_step(input bit v, input int x, input int d, input bit st);
        int cx;
        int cd;
        cx = x - (1 << (WX - 1));
        cd = d - (1 << (WD - 1));
        case (m_mode)
            0: begin
                if (v) begin
                    m_x = sat(cx - m_ofs_x, WX);
                    m_d = sat(cd - m_ofs_d, WD);
                end
                m_ov = v;
                if (st) begin
                    m_mode = 1; m_sum_x = 0; m_sum_d = 0; m_n = 0;
                end
            end
            1: begin
                m_ov = 0; m_x = 0; m_d = 0;
                if (v) begin
                    m_sum_x += cx;
                    m_sum_d += cd;
                    m_n++;
                    if (m_n == N) begin
                        m_mode = 2;
                        m_n = 0;
                    end
                end
            end
            default: begin
                if (v) begin
                    m_x = sat(cx - m_ofs_x, WX);
                    m_d = sat(cd - m_ofs_d, WD);
                end
                m_ov = v;
                m_ofs_x = floor_div(m_sum_x, N);
                m_ofs_d = floor_div(m_sum_d, N);
                m_mode = 0;
            end
        endcase
        m_busy = (m_mode != 0) ? 1 : 0;
        m_done = (m_mode == 2) ? 1 : 0;
    endtask

    task automatic compare_all();
        check("x_out", int'(x_out), m_x);
        check("d_out", int'(d_out), m_d);
        check("out_valid", int'(out_valid), m_ov);
        check("cal_busy", int'(cal_busy), m_busy);
        check("cal_done", int'(cal_done), m_done);
        check("ofs_x", int'(ofs_x), m_ofs_x);
        check("ofs_d", int'(ofs_d), m_ofs_d);
    endtask

    task automatic step(input bit v, input int x, input int d, input bit st);
        adc_valid = v;
        adc_x     = x[WX-1:0];
        adc_d     = d[WD-1:0];
        cal_start = st;
        model_step(v, x, d, st);
        @(posedge clk);
        #1;
        if (cal_done) done_count++;
        compare_all();
    endtask

    // Asynchronous reset: outputs must clear without a clock edge.
    task automatic do_reset();
        adc_valid = 1'b0;
        cal_start = 1'b0;
        reset = 1'b0;
        #1;
        model_clear();
        compare_all();
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 12'h800, 14'h2000, 1'b0);
    endtask

    initial begin
        reset = 1'b1; adc_x = '0; adc_d = '0; adc_valid = 1'b0; cal_start = 1'b0;
        model_clear();
        #3;
        do_reset();

        // Pass-through with zero offsets
        tbl[0] = '{1'b1, 12'h810, 14'h2000,    16,     0, 1};
        tbl[1] = '{1'b1, 12'h000, 14'h0000, -2048, -8192, 1};
        tbl[2] = '{1'b1, 12'hFFF, 14'h3FFF,  2047,  8191, 1};
        tbl[3] = '{1'b0, 12'h123, 14'h0456,  2047,  8191, 0};
        tbl[4] = '{1'b1, 12'h800, 14'h1F9C,     0,  -100, 1};
        tbl[5] = '{1'b1, 12'h7FF, 14'h2001,    -1,     1, 1};
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].v, tbl[i].x, tbl[i].d, 1'b0);
            check("tbl_x", int'(x_out), tbl[i].ex);
            check("tbl_d", int'(d_out), tbl[i].ed);
            check("tbl_ov", int'(out_valid), tbl[i].eov);
        end

        // Abort after 100 samples: offsets stay at zero
        step(1'b0, 12'h800, 14'h2000, 1'b1);
        for (int i = 0; i < 100; i++) step(1'b1, 12'h000, 14'h0000, 1'b0);
        do_reset();
        check("abort_ofs_x", int'(ofs_x), 0);
        check("abort_busy", int'(cal_busy), 0);
        step(1'b1, 12'h810, 14'h2000, 1'b0);
        check("abort_pass_x", int'(x_out), 16);

        // Calibration; the start-cycle sample must not be accumulated
        done_count = 0;
        step(1'b1, 12'hFFF, 14'h3FFF, 1'b1);
        check("start_sample_x", int'(x_out), 2047);
        for (int i = 0; i < N; i++) step(1'b1, 12'h810, 14'h1F9C, 1'b0);
        step(1'b0, 12'h800, 14'h2000, 1'b0);
        check("cal_ofs_x", int'(ofs_x), 16);
        check("cal_ofs_d", int'(ofs_d), -100);
        check("cal_done_pulses", done_count, 1);
        step(1'b1, 12'h810, 14'h1F9C, 1'b0);
        check("cal_res_x", int'(x_out), 0);
        check("cal_res_d", int'(d_out), 0);

        // Rounding toward minus infinity
        step(1'b0, 12'h800, 14'h2000, 1'b1);
        for (int i = 0; i < N / 2; i++) step(1'b1, 12'h7FF, 14'h2000, 1'b0);
        for (int i = 0; i < N / 2; i++) step(1'b1, 12'h800, 14'h2000, 1'b0);
        step(1'b0, 12'h800, 14'h2000, 1'b0);
        check("round_ofs_x", int'(ofs_x), -1);
        check("round_ofs_d", int'(ofs_d), 0);

        // Gapped valid plus an ignored re-start during calibration
        done_count = 0;
        step(1'b0, 12'h800, 14'h2000, 1'b1);
        for (int i = 0; i < 2 * N; i++) begin
            step((i % 2) == 0, $urandom_range(0, 4095), $urandom_range(0, 16383), i == 101);
            if (i == 2 * N - 3) check("gap_busy_mid", int'(cal_busy), 1);
        end
        check("gap_busy_end", int'(cal_busy), 0);
        check("gap_done_pulses", done_count, 1);

        // Saturation with the most negative offset
        step(1'b0, 12'h800, 14'h2000, 1'b1);
        for (int i = 0; i < N; i++) step(1'b1, 12'h000, 14'h0000, 1'b0);
        step(1'b0, 12'h800, 14'h2000, 1'b0);
        check("sat_ofs_x", int'(ofs_x), -2048);
        check("sat_ofs_d", int'(ofs_d), -8192);
        step(1'b1, 12'hFFF, 14'h3FFF, 1'b0);
        check("sat_hi_x", int'(x_out), 2047);
        check("sat_hi_d", int'(d_out), 8191);
        step(1'b1, 12'h000, 14'h0000, 1'b0);
        check("sat_zero_x", int'(x_out), 0);
        check("sat_zero_d", int'(d_out), 0);

        // Random traffic with occasional calibration requests
        for (int i = 0; i < 1200; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 4095),
                 $urandom_range(0, 16383), $urandom_range(0, 149) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
